lcd_frame_monitor: RTL and testbench

//   Receive end of the parallel RGB LCD bus (pixel tick, hs_n, vs_n, data_enable, 8:8:8 RGB).

---
 rtl/lcd_frame_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_frame_monitor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_monitor.sv
// rtl/lcd_frame_monitor.sv - receive-side monitor for a parallel RGB LCD bus
//
// Purpose:
//   Recovers pixel x/y coordinates from the sampled LCD bus, measures the
//   active geometry of each frame and counts the frames. A frame is flagged
//   as malformed when a line width or the line count differs from the
//   expected geometry, when a counter saturates, or when data_enable is
//   high during a sync pulse. The partial frame seen after reset is never
//   reported.
//
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   tick                      pixel enable; the bus is sampled only when high
//   hs_n, vs_n, data_enable   LCD sync (active low) and active-pixel qualifier
//   red, green, blue          incoming pixel colour
//   pixel_valid               one-clock pulse: x, y, *_out hold a captured pixel
//   x, y                      coordinates of the captured pixel
//   red_out/green_out/blue_out  captured colour
//   frame_done                one-clock pulse: frame statistics updated
//   width, height             last line width / line count of completed frame
//   frame_count               completed frames (wraps)
//   geom_error                completed frame was malformed (held)
//   crc                       per-frame pixel CRC-16-CCITT
//
// Configuration macro:
//   LCD_MONITOR_CRC_EN  enables the per-frame CRC; otherwise crc is 16'h0000.

module lcd_frame_monitor #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          hs_n,
  input  logic          vs_n,
  input  logic          data_enable,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic          pixel_valid,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          frame_done,
  output logic [XW-1:0] width,
  output logic [YW-1:0] height,
  output logic [15:0]   frame_count,
  output logic          geom_error,
  output logic [15:0]   crc
);

  localparam logic [XW-1:0] H_EXP = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_EXP = YW'(V_ACTIVE);
  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;

  typedef enum logic {WAIT_VS, IN_FRAME} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_cnt, last_w;
  logic [YW-1:0] line_cnt;
  logic          err_acc, prev_de, prev_vs;
  logic          vs_fall, de_fall;

  logic [XW-1:0] x_nx, last_w_nx, pix_x;
  logic [YW-1:0] line_nx, pix_y, close_h;
  logic          err_nx, close_err;

  assign vs_fall = prev_vs & ~vs_n;
  assign de_fall = prev_de & ~data_enable;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= WAIT_VS;
    else          state_q <= state_d;
  end

  // The first vs_fall after reset only arms; frames are closed from IN_FRAME.
  always_comb begin
    state_d = state_q;
    if (tick && vs_fall && state_q == WAIT_VS) state_d = IN_FRAME;
  end

  // Per-tick update, evaluated in order: line end, frame end, active pixel.
  always_comb begin
    x_nx      = x_cnt;
    line_nx   = line_cnt;
    err_nx    = err_acc;
    last_w_nx = last_w;
    if (de_fall) begin
      last_w_nx = x_cnt;
      if (x_cnt != H_EXP) err_nx = 1'b1;
      if (line_cnt == Y_MAX) err_nx = 1'b1;
      else                   line_nx = line_cnt + 1'b1;
      x_nx = '0;
    end
    // Frame statistics include a line that ended on this same tick.
    close_h   = line_nx;
    close_err = err_nx | (line_nx != V_EXP);
    if (vs_fall) begin
      line_nx = '0;
      err_nx  = 1'b0;
      x_nx    = '0;
    end
    // A pixel on the vs_fall tick is the first pixel of the new frame.
    pix_x = x_nx;
    pix_y = line_nx;
    if (data_enable) begin
      if (x_nx == X_MAX) err_nx = 1'b1;
      else               x_nx   = x_nx + 1'b1;
      if (!hs_n || !vs_n) err_nx = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt       <= '0;
      line_cnt    <= '0;
      last_w      <= '0;
      err_acc     <= 1'b0;
      prev_de     <= 1'b0;
      prev_vs     <= 1'b1;
      pixel_valid <= 1'b0;
      x           <= '0;
      y           <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      frame_done  <= 1'b0;
      width       <= '0;
      height      <= '0;
      frame_count <= '0;
      geom_error  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (tick) begin
        prev_vs <= vs_n;
        prev_de <= data_enable;
        if (state_q == IN_FRAME) begin
          x_cnt    <= x_nx;
          line_cnt <= line_nx;
          err_acc  <= err_nx;
          last_w   <= last_w_nx;
          if (vs_fall) begin
            frame_done  <= 1'b1;
            width       <= last_w_nx;
            height      <= close_h;
            geom_error  <= close_err;
            frame_count <= frame_count + 16'd1;
          end
          if (data_enable) begin
            pixel_valid <= 1'b1;
            x           <= pix_x;
            y           <= pix_y;
            red_out     <= red;
            green_out   <= green;
            blue_out    <= blue;
          end
        end
      end
    end
  end

`ifdef LCD_MONITOR_CRC_EN
  logic [15:0] crc_acc, crc_nx;

  // CRC-16-CCITT, poly 0x1021, MSB first over {red,green,blue}.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_nx = crc_acc;
    if (vs_fall)     crc_nx = 16'hFFFF;
    if (data_enable) crc_nx = crc_step(crc_nx, {red, green, blue});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_acc <= 16'hFFFF;
      crc     <= '0;
    end else if (tick) begin
      if (state_q == IN_FRAME) begin
        crc_acc <= crc_nx;
        if (vs_fall) crc <= crc_acc;
      end else if (vs_fall) begin
        crc_acc <= 16'hFFFF;
      end
    end
  end
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_frame_monitor.sv
// tb/tb_lcd_frame_monitor.sv - self-checking bench for lcd_frame_monitor
module tb_lcd_frame_monitor;

  logic        clock = 1'b0;
  logic        reset_n, tick, hs_n, vs_n, data_enable;
  logic [7:0]  red, green, blue;
  logic        pixel_valid, frame_done, geom_error;
  logic [9:0]  x, y, width, height;
  logic [7:0]  red_out, green_out, blue_out;
  logic [15:0] frame_count, crc;

  always #5 clock = ~clock;

  lcd_frame_monitor #(.H_ACTIVE(4), .V_ACTIVE(3), .XW(10), .YW(10)) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .hs_n(hs_n), .vs_n(vs_n),
    .data_enable(data_enable), .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .x(x), .y(y),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_done(frame_done), .width(width), .height(height),
    .frame_count(frame_count), .geom_error(geom_error), .crc(crc)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef struct packed {
    logic [9:0]  w;
    logic [9:0]  h;
    logic        err;
    logic [15:0] fc;
    logic [15:0] crc;
  } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state
  bit          armed = 1'b0;
  int          cur_lines = 0;
  int          cur_last_w = 0;
  bit          cur_err = 1'b0;
  logic [15:0] cur_crc = 16'hFFFF;
  logic [15:0] fc_m = 16'd0;
  int          seed = 0;
  bit          zero_px = 1'b0;
  int          pv_seen = 0;
  int          fd_seen = 0;
  bit          pv_prev = 1'b0;
  bit          fd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc8(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic next_rgb(output logic [23:0] rgb);
    if (zero_px) rgb = 24'h0;
    else begin
      seed++;
      rgb = {8'(seed), 8'(seed * 3), 8'(seed ^ 8'h5A)};
    end
  endtask

  task automatic bus(input logic h, input logic v, input logic de, input logic [23:0] rgb);
    @(negedge clock);
    hs_n = h; vs_n = v; data_enable = de;
    {red, green, blue} = rgb;
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic expect_pixel(input int px, input int py, input logic [23:0] rgb);
    pix_t p;
    if (armed) begin
      p.x = 10'(px); p.y = 10'(py); p.rgb = rgb;
      pq.push_back(p);
      cur_crc = crc8(crc8(crc8(cur_crc, rgb[23:16]), rgb[15:8]), rgb[7:0]);
    end
  endtask

  task automatic line(input int x0, input int n, input bit hs_bad, input bit tail);
    logic [23:0] rgb;
    for (int i = 0; i < n; i++) begin
      next_rgb(rgb);
      expect_pixel(x0 + i, cur_lines, rgb);
      bus((hs_bad && i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, rgb);
    end
    cur_lines++;
    cur_last_w = x0 + n;
    if (x0 + n != 4) cur_err = 1'b1;
    if (hs_bad) cur_err = 1'b1;
    if (tail) begin
      bus(1'b0, 1'b1, 1'b0, 24'h0);
      bus(1'b1, 1'b1, 1'b0, 24'h0);
    end
  endtask

  task automatic close_frame();
    frm_t f;
    if (armed) begin
      fc_m++;
      f.w   = 10'(cur_last_w);
      f.h   = 10'(cur_lines);
      f.err = cur_err || (cur_lines != 3);
      f.fc  = fc_m;
`ifdef LCD_MONITOR_CRC_EN
      f.crc = cur_crc;
`else
      f.crc = 16'h0000;
`endif
      fq.push_back(f);
    end
    armed     = 1'b1;
    cur_lines = 0;
    cur_err   = 1'b0;
    cur_crc   = 16'hFFFF;
  endtask

  task automatic vsync();
    close_frame();
    bus(1'b1, 1'b0, 1'b0, 24'h0);
    bus(1'b1, 1'b0, 1'b0, 24'h0);
    bus(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  // vs_fall tick that also carries the first pixel of the new frame
  task automatic vsync_de();
    logic [23:0] rgb;
    close_frame();
    next_rgb(rgb);
    expect_pixel(0, 0, rgb);
    cur_err = 1'b1;
    bus(1'b1, 1'b0, 1'b1, rgb);
  endtask

  task automatic clean_frame();
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
  endtask

  // Compare process: every clock, #1 after the edge.
  always @(posedge clock) begin
    pix_t pe;
    frm_t fe;
    #1;
    if (reset_n) begin
      if (pixel_valid) begin
        pv_seen++;
        chk("pixel_valid_width", 32'(pv_prev), 32'd0);
        chk("pixel_expected", 32'(pq.size() != 0), 32'd1);
        if (pq.size() != 0) begin
          pe = pq.pop_front();
          chk("pix_x", 32'(x), 32'(pe.x));
          chk("pix_y", 32'(y), 32'(pe.y));
          chk("pix_rgb", 32'({red_out, green_out, blue_out}), 32'(pe.rgb));
        end
      end
      if (frame_done) begin
        fd_seen++;
        chk("frame_done_width", 32'(fd_prev), 32'd0);
        chk("frame_expected", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) begin
          fe = fq.pop_front();
          chk("frm_width", 32'(width), 32'(fe.w));
          chk("frm_height", 32'(height), 32'(fe.h));
          chk("frm_geom_error", 32'(geom_error), 32'(fe.err));
          chk("frm_count", 32'(frame_count), 32'(fe.fc));
          chk("frm_crc", 32'(crc), 32'(fe.crc));
        end
      end
    end
    pv_prev = pixel_valid;
    fd_prev = frame_done;
  end

  initial begin
    int          pv0, fd0;
    logic [15:0] crc_zero;
    reset_n = 1'b0; tick = 1'b0; hs_n = 1'b1; vs_n = 1'b1; data_enable = 1'b0;
    red = 8'h0; green = 8'h0; blue = 8'h0;
    repeat (3) @(negedge clock);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_width_height", 32'({width, height}), 32'd0);
    chk("rst_geom_error", 32'(geom_error), 32'd0);
    chk("rst_crc", 32'(crc), 32'd0);
    reset_n = 1'b1;

    // 1. Two clean frames; first vs_fall only arms.
    line(0, 4, 1'b0, 1'b1);           // pre-arm line, ignored
    chk("no_pixel_before_arm", 32'(pv_seen), 32'd0);
    vsync();
    chk("no_frame_done_at_arm", 32'(fd_seen), 32'd0);
    pv0 = pv_seen;
    clean_frame();
    chk("f1_pixel_count", 32'(pv_seen - pv0), 32'd12);
    vsync();
    chk("f1_frame_done_once", 32'(fd_seen), 32'd1);
    chk("f1_literal", 32'({width, height, geom_error, frame_count}),
        32'({10'd4, 10'd3, 1'b0, 16'd1}));
    clean_frame();
    vsync();

    // 2. Line 1 has 5 pixels, then a clean frame.
    line(0, 4, 1'b0, 1'b1);
    line(0, 5, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    vsync();
    chk("wide_line_err", 32'(geom_error), 32'd1);
    chk("wide_line_width", 32'(width), 32'd4);
    clean_frame();
    vsync();
    chk("clean_after_wide", 32'(geom_error), 32'd0);

    // 3. Two-line frame, then a frame with DE during hs_n low.
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    vsync();
    chk("short_frame_height", 32'(height), 32'd2);
    chk("short_frame_err", 32'(geom_error), 32'd1);
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b1, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    vsync();
    chk("de_in_hsync_err", 32'(geom_error), 32'd1);

    // 4a. DE falls on the vs_fall tick: line belongs to the closing frame.
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b0);
    vsync();
    chk("de_fall_on_vs_height", 32'(height), 32'd3);
    chk("de_fall_on_vs_err", 32'(geom_error), 32'd0);

    // 4b. DE rises on the vs_fall tick.
    clean_frame();
    vsync_de();
    chk("de_rise_on_vs_xy", 32'({x, y}), 32'd0);
    chk("de_rise_on_vs_prior", 32'({height, geom_error}), 32'({10'd3, 1'b0}));
    line(1, 3, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    line(0, 4, 1'b0, 1'b1);
    vsync();
    chk("de_in_vsync_err", 32'(geom_error), 32'd1);

    // 6. All-zero frame CRC.
    zero_px = 1'b1;
    clean_frame();
    vsync();
    zero_px = 1'b0;
`ifdef LCD_MONITOR_CRC_EN
    crc_zero = 16'hFFFF;
    for (int i = 0; i < 36; i++) crc_zero = crc8(crc_zero, 8'h00);
    chk("crc_zero_frame", 32'(crc), 32'(crc_zero));
`else
    crc_zero = 16'h0000;
    chk("crc_disabled", 32'(crc), 32'(crc_zero));
`endif

    // 5. Reset mid-line.
    line(0, 2, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pulses", 32'({pixel_valid, frame_done}), 32'd0);
    chk("async_rst_xy", 32'({x, y}), 32'd0);
    chk("async_rst_rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    chk("async_rst_stats", 32'({width, height, geom_error}), 32'd0);
    chk("async_rst_count_crc", 32'({frame_count, crc}), 32'd0);
    chk("queues_drained_at_rst", 32'(pq.size() + fq.size()), 32'd0);
    pq.delete(); fq.delete();
    armed = 1'b0; fc_m = 16'd0; cur_lines = 0; cur_err = 1'b0; cur_last_w = 0;
    hs_n = 1'b1; vs_n = 1'b1; data_enable = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    pv0 = pv_seen; fd0 = fd_seen;
    line(0, 3, 1'b0, 1'b1);
    chk("post_rst_no_pixel", 32'(pv_seen - pv0), 32'd0);
    vsync();
    chk("post_rst_no_frame_done", 32'(fd_seen - fd0), 32'd0);
    clean_frame();
    vsync();
    chk("post_rst_frame_count", 32'(frame_count), 32'd1);
    chk("post_rst_frame_done_once", 32'(fd_seen - fd0), 32'd1);

    repeat (4) @(negedge clock);
    chk("pixels_left", 32'(pq.size()), 32'd0);
    chk("frames_left", 32'(fq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
